// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 subordinate memory responder.
// Channel structs mirror the ariane_axi req_t/resp_t layout at 4-bit id, 64-bit addr/data.
package axi_mem_pkg;

  localparam int ID_W   = 4;
  localparam int USER_W = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_DATA = 3'd1,
    W_RESP = 3'd2,
    R_WAIT = 3'd3,
    R_DATA = 3'd4
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } xact_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [63:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [USER_W-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [63:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0]       data;
    logic [7:0]        strb;
    logic              last;
    logic [USER_W-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [63:0]       data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  localparam int REQ_W  = $bits(req_t);
  localparam int RESP_W = $bits(resp_t);

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Flags reserved burst types and WRAP lengths other than 2/4/8/16 beats.
module axi_burst_addr_gen
  import axi_mem_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [63:0] next_addr,
  output logic        illegal
);

  logic [63:0] step;
  logic [63:0] incr_addr;
  logic [63:0] wrap_mask;

  always_comb begin
    step      = 64'd1 << size;
    incr_addr = addr + step;
    // total burst span in bytes minus one; only a clean mask for legal WRAP lengths
    wrap_mask = ((({56'd0, len}) + 64'd1) << size) - 64'd1;
    next_addr = addr;
    illegal   = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP: begin
        next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        illegal   = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
      end
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a 64-bit word array, one transaction outstanding at a time.
// Read/write ties are arbitrated by a flag that flips after each tied grant.
//
// state  | meaning
// IDLE   | waiting for AW or AR; readies offered to the granted channel only
// W_DATA | accepting write beats until count==len or w_last
// W_RESP | presenting B until b_ready
// R_WAIT | read latency countdown
// R_DATA | presenting R beats, held while r_ready is low
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned MemWords    = 1024,
  parameter int unsigned ReadLatency = 1,
  parameter logic [63:0] BaseAddr    = 64'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REQ_W-1:0]  axi_req_i,
  output logic [RESP_W-1:0] axi_resp_o,
  output logic              busy_o
);

  localparam int unsigned IDX_W    = $clog2(MemWords);
  localparam logic [3:0]  LAT_INIT = 4'(ReadLatency - 1);

  req_t        req;
  resp_t       resp;
  state_e      state, state_nxt;
  xact_t       xact, aw_xact, ar_xact;
  logic [7:0]  beat_cnt;
  logic [3:0]  lat_cnt;
  logic        err;
  logic        prio_w;
  logic        grant_w, grant_r;
  logic        w_beat, r_beat, last_beat;
  logic [63:0] next_addr, offset;
  logic        burst_illegal, in_range;
  logic [IDX_W-1:0] word_idx;
  logic [63:0] mem [MemWords];

  assign req        = req_t'(axi_req_i);
  assign axi_resp_o = resp;

  assign aw_xact = {req.aw.id, req.aw.addr, req.aw.len, req.aw.size, req.aw.burst};
  assign ar_xact = {req.ar.id, req.ar.addr, req.ar.len, req.ar.size, req.ar.burst};

  // prio_w=0 favours READ on a tie
  assign grant_w = (state == IDLE) && req.aw_valid && (!req.ar_valid || prio_w);
  assign grant_r = (state == IDLE) && req.ar_valid && (!req.aw_valid || !prio_w);

  assign last_beat = (beat_cnt == xact.len);
  assign w_beat    = (state == W_DATA) && req.w_valid;
  assign r_beat    = (state == R_DATA) && req.r_ready;

  assign offset   = xact.addr - BaseAddr;
  assign in_range = (xact.addr >= BaseAddr) && (offset[63:3+IDX_W] == '0);
  assign word_idx = offset[3+IDX_W-1:3];

  axi_burst_addr_gen u_addr_gen (
    .addr      (xact.addr),
    .size      (xact.size),
    .len       (xact.len),
    .burst     (xact.burst),
    .next_addr (next_addr),
    .illegal   (burst_illegal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_w)      state_nxt = W_DATA;
        else if (grant_r) state_nxt = R_WAIT;
      end
      W_DATA: if (w_beat && (last_beat || req.w.last)) state_nxt = W_RESP;
      W_RESP: if (req.b_ready) state_nxt = IDLE;
      R_WAIT: if (lat_cnt == '0) state_nxt = R_DATA;
      R_DATA: if (r_beat && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp          = '0;
    resp.aw_ready = grant_w;
    resp.ar_ready = grant_r;
    resp.w_ready  = (state == W_DATA);
    if (state == W_RESP) begin
      resp.b_valid = 1'b1;
      resp.b.id    = xact.id;
      resp.b.resp  = err ? RESP_SLVERR : RESP_OKAY;
    end
    if (state == R_DATA) begin
      resp.r_valid = 1'b1;
      resp.r.id    = xact.id;
      resp.r.last  = last_beat;
      resp.r.data  = in_range ? mem[word_idx] : 64'd0;
      resp.r.resp  = (!in_range || burst_illegal) ? RESP_SLVERR : RESP_OKAY;
    end
    busy_o = (state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xact     <= '0;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      err      <= 1'b0;
      prio_w   <= 1'b0;
    end else begin
      if (grant_w || grant_r) begin
        xact     <= grant_w ? aw_xact : ar_xact;
        beat_cnt <= '0;
        lat_cnt  <= LAT_INIT;
        err      <= 1'b0;
        if (req.aw_valid && req.ar_valid) prio_w <= ~prio_w;
      end
      if (w_beat) begin
        xact.addr <= next_addr;
        beat_cnt  <= beat_cnt + 8'd1;
        if (!in_range || burst_illegal || (req.w.last != last_beat)) err <= 1'b1;
      end
      if ((state == R_WAIT) && (lat_cnt != '0)) lat_cnt <= lat_cnt - 4'd1;
      if (r_beat) begin
        xact.addr <= next_addr;
        beat_cnt  <= beat_cnt + 8'd1;
      end
      if ((state == W_RESP) && req.b_ready) err <= 1'b0;
    end
  end

  // backing store is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (w_beat && in_range && !burst_illegal) begin
      for (int b = 0; b < 8; b++) begin
        if (req.w.strb[b]) mem[word_idx][8*b +: 8] <= req.w.data[8*b +: 8];
      end
    end
  end

  logic unused_fields;
  assign unused_fields = ^{req.aw.lock, req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region,
                           req.aw.atop, req.aw.user, req.ar.lock, req.ar.cache, req.ar.prot,
                           req.ar.qos, req.ar.region, req.ar.user, req.w.user, offset[2:0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: write/read bursts, a table of read vectors,
// stall stability, tie arbitration and reset in the middle of a write burst.
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  localparam int          MEM_WORDS = 1024;
  localparam int          READ_LAT  = 3;
  localparam logic [63:0] BASE      = 64'h8000_0000;
  localparam logic [63:0] OOR       = BASE + 64'(MEM_WORDS) * 64'd8;

  logic  clk;
  logic  rst_ni;
  req_t  req;
  resp_t resp;
  logic  busy;

  int n_tests = 0;
  int n_fail  = 0;

  axi_mem_responder #(
    .MemWords    (MEM_WORDS),
    .ReadLatency (READ_LAT),
    .BaseAddr    (BASE)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .axi_req_i  (req),
    .axi_resp_o (resp),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]       id;
    logic [63:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       chk_mask;
    logic [3:0][63:0] exp_data;
    logic [3:0][1:0]  exp_resp;
  } rd_vec_t;

  localparam int NV = 10;
  rd_vec_t vecs[NV];

  function automatic rd_vec_t mk(input logic [3:0] id, input logic [63:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst, input logic [3:0] mask,
                                 input logic [3:0][63:0] d, input logic [3:0][1:0] r);
    rd_vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.chk_mask = mask; v.exp_data = d; v.exp_resp = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return resp.aw_ready;
      1: return resp.ar_ready;
      2: return resp.w_ready;
      3: return resp.b_valid;
      default: return resp.r_valid;
    endcase
  endfunction

  // returns at the negedge where the selected signal is high; cyc counts negedges consumed
  task automatic wait_for(input string name, input int sel, output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!sig(sel) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!sig(sel)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got 0 expected 1", name);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int c;
    req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
    req.aw.size = size; req.aw.burst = burst; req.aw_valid = 1'b1;
    wait_for("aw_ready", 0, c);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int c;
    req.ar.id = id; req.ar.addr = addr; req.ar.len = len;
    req.ar.size = size; req.ar.burst = burst; req.ar_valid = 1'b1;
    wait_for("ar_ready", 1, c);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
  endtask

  task automatic wr_burst(input string name, input logic [3:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [3:0][63:0] data,
                          input logic [7:0] strb, input int last_at, input logic [1:0] exp_resp);
    int c;
    do_aw(id, addr, len, 3'd3, BURST_INCR);
    for (int i = 0; i <= last_at; i++) begin
      req.w.data = data[i]; req.w.strb = strb; req.w.last = (i == last_at); req.w_valid = 1'b1;
      wait_for("w_ready", 2, c);
      @(posedge clk); #1;
      req.w_valid = 1'b0; req.w.last = 1'b0;
    end
    @(negedge clk);
    chk({name, "_b_next_cycle"}, 64'(resp.b_valid), 64'd1);
    if (!resp.b_valid) wait_for("b_valid", 3, c);
    chk({name, "_b_resp"}, 64'(resp.b.resp), 64'(exp_resp));
    chk({name, "_b_id"}, 64'(resp.b.id), 64'(id));
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          output logic [3:0][63:0] d, output logic [3:0][1:0] rr,
                          output logic [3:0] lst, output logic [3:0][3:0] rid);
    int c;
    d = '0; rr = '0; lst = '0; rid = '0;
    do_ar(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      wait_for("r_valid", 4, c);
      d[i] = resp.r.data; rr[i] = resp.r.resp; lst[i] = resp.r.last; rid[i] = resp.r.id;
      req.r_ready = 1'b1;
      @(posedge clk); #1;
      req.r_ready = 1'b0;
    end
  endtask

  // first beat stalled 5 cycles with r_ready low; outputs must match the constants every cycle
  task automatic stall_read(input string name, input logic [63:0] addr, input logic [7:0] len,
                            input logic [63:0] exp_d, input logic [1:0] exp_r, input logic exp_l);
    int c;
    do_ar(4'd12, addr, len, 3'd3, BURST_INCR);
    wait_for("r_valid", 4, c);
    chk({name, "_latency"}, 64'(c), 64'(READ_LAT + 1));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_stall%0d_valid", name, k), 64'(resp.r_valid), 64'd1);
      chk($sformatf("%s_stall%0d_data", name, k), resp.r.data, exp_d);
      chk($sformatf("%s_stall%0d_resp", name, k), 64'(resp.r.resp), 64'(exp_r));
      chk($sformatf("%s_stall%0d_last", name, k), 64'(resp.r.last), 64'(exp_l));
      @(negedge clk);
    end
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0) wait_for("r_valid", 4, c);
      req.r_ready = 1'b1;
      @(posedge clk); #1;
      req.r_ready = 1'b0;
    end
  endtask

  initial begin
    logic [3:0][63:0] d;
    logic [3:0][1:0]  rr;
    logic [3:0]       lst;
    logic [3:0][3:0]  rid;
    logic [7:0]       g [3];
    int               ng, both, c;

    vecs[0] = mk(4'd1, BASE, 8'd3, 3'd3, BURST_INCR, 4'hF,
                 {64'd4, 64'd3, 64'd2, 64'd1}, {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY});
    vecs[1] = mk(4'd2, BASE + 64'h18, 8'd3, 3'd3, BURST_WRAP, 4'hF,
                 {64'd3, 64'd2, 64'd1, 64'd4}, {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY});
    vecs[2] = mk(4'd3, BASE + 64'h8, 8'd2, 3'd3, BURST_FIXED, 4'h7,
                 {64'd0, 64'd2, 64'd2, 64'd2}, {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY});
    vecs[3] = mk(4'd4, BASE, 8'd1, 3'd2, BURST_INCR, 4'h3,
                 {64'd0, 64'd0, 64'd1, 64'd1}, {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY});
    vecs[4] = mk(4'd5, BASE + 64'h80, 8'd0, 3'd3, BURST_INCR, 4'h1,
                 {64'd0, 64'd0, 64'd0, 64'h0000_0000_FFFF_FFFF},
                 {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY});
    vecs[5] = mk(4'd6, OOR, 8'd0, 3'd3, BURST_INCR, 4'h1,
                 {64'd0, 64'd0, 64'd0, 64'd0}, {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_SLVERR});
    vecs[6] = mk(4'd7, BASE - 64'd8, 8'd0, 3'd3, BURST_INCR, 4'h1,
                 {64'd0, 64'd0, 64'd0, 64'd0}, {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_SLVERR});
    vecs[7] = mk(4'd8, BASE, 8'd2, 3'd3, BURST_WRAP, 4'h0,
                 {64'd0, 64'd0, 64'd0, 64'd0}, {RESP_OKAY, RESP_SLVERR, RESP_SLVERR, RESP_SLVERR});
    vecs[8] = mk(4'd9, BASE, 8'd0, 3'd3, 2'b11, 4'h0,
                 {64'd0, 64'd0, 64'd0, 64'd0}, {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_SLVERR});
    vecs[9] = mk(4'd10, OOR - 64'd8, 8'd1, 3'd3, BURST_INCR, 4'h2,
                 {64'd0, 64'd0, 64'd0, 64'd0}, {RESP_OKAY, RESP_OKAY, RESP_SLVERR, RESP_OKAY});

    req    = '0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
    chk("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
    chk("rst_w_ready", 64'(resp.w_ready), 64'd0);
    chk("rst_b_valid", 64'(resp.b_valid), 64'd0);
    chk("rst_r_valid", 64'(resp.r_valid), 64'd0);
    chk("rst_b_fields", 64'({resp.b.id, resp.b.resp, resp.b.user}), 64'd0);
    chk("rst_r_data", resp.r.data, 64'd0);
    chk("rst_r_fields", 64'({resp.r.id, resp.r.resp, resp.r.last, resp.r.user}), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    wr_burst("wr_incr", 4'd3, BASE, 8'd3, {64'd4, 64'd3, 64'd2, 64'd1}, 8'hFF, 3, RESP_OKAY);
    wr_burst("wr_zero", 4'd4, BASE + 64'h80, 8'd0, '0, 8'hFF, 0, RESP_OKAY);
    wr_burst("wr_strb", 4'd5, BASE + 64'h80, 8'd0, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 8'h0F, 0,
             RESP_OKAY);
    wr_burst("wr_oor", 4'd6, OOR, 8'd0, {192'd0, 64'hDEAD}, 8'hFF, 0, RESP_SLVERR);
    wr_burst("wr_early_last", 4'd7, BASE + 64'h100, 8'd1, {192'd0, 64'h77}, 8'hFF, 0,
             RESP_SLVERR);

    for (int v = 0; v < NV; v++) begin
      rd_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
               d, rr, lst, rid);
      for (int i = 0; i <= int'(vecs[v].len); i++) begin
        if (vecs[v].chk_mask[i])
          chk($sformatf("rd%0d_b%0d_data", v, i), d[i], vecs[v].exp_data[i]);
        chk($sformatf("rd%0d_b%0d_resp", v, i), 64'(rr[i]), 64'(vecs[v].exp_resp[i]));
        chk($sformatf("rd%0d_b%0d_last", v, i), 64'(lst[i]), 64'(i == int'(vecs[v].len)));
        chk($sformatf("rd%0d_b%0d_id", v, i), 64'(rid[i]), 64'(vecs[v].id));
      end
    end

    stall_read("stall_oor", OOR, 8'd0, 64'd0, RESP_SLVERR, 1'b1);
    stall_read("stall_incr", BASE, 8'd1, 64'd1, RESP_OKAY, 1'b0);

    // both AW and AR held valid across three idle windows; expect R, W, R
    g[0] = 8'h0; g[1] = 8'h0; g[2] = 8'h0;
    ng = 0; both = 0;
    req.aw.id = 4'd13; req.aw.addr = BASE + 64'h40; req.aw.len = 8'd0;
    req.aw.size = 3'd3; req.aw.burst = BURST_INCR;
    req.ar.id = 4'd14; req.ar.addr = BASE + 64'h40; req.ar.len = 8'd0;
    req.ar.size = 3'd3; req.ar.burst = BURST_INCR;
    req.w.data = 64'h55; req.w.strb = 8'hFF; req.w.last = 1'b1; req.w_valid = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    req.aw_valid = 1'b1; req.ar_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && ng < 3; cyc++) begin
      @(negedge clk);
      if (resp.aw_ready && resp.ar_ready) both++;
      if (resp.ar_ready) begin g[ng] = "R"; ng++; end
      else if (resp.aw_ready) begin g[ng] = "W"; ng++; end
      @(posedge clk); #1;
    end
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    for (int cyc = 0; cyc < 60 && busy; cyc++) @(posedge clk);
    #1;
    req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b0; req.r_ready = 1'b0;
    chk("arb_grant0", 64'(g[0]), 64'("R"));
    chk("arb_grant1", 64'(g[1]), 64'("W"));
    chk("arb_grant2", 64'(g[2]), 64'("R"));
    chk("arb_both_ready_cycles", 64'(both), 64'd0);
    chk("arb_idle_after", 64'(busy), 64'd0);

    // reset asserted while the third beat of a 4-beat write is being offered
    do_aw(4'd15, BASE, 8'd3, 3'd3, BURST_INCR);
    for (int i = 0; i < 2; i++) begin
      req.w.data = 64'hA0 + 64'(i); req.w.strb = 8'hFF; req.w_valid = 1'b1;
      wait_for("w_ready", 2, c);
      @(posedge clk); #1;
    end
    req.w.data = 64'hA2;
    @(negedge clk);
    chk("mid_busy_before_rst", 64'(busy), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_w_ready", 64'(resp.w_ready), 64'd0);
    chk("mid_rst_valids", 64'({resp.b_valid, resp.r_valid}), 64'd0);
    @(posedge clk); #1;
    chk("mid_next_busy", 64'(busy), 64'd0);
    chk("mid_next_valids", 64'({resp.b_valid, resp.r_valid, resp.w_ready}), 64'd0);
    req.w_valid = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    rd_burst(4'd1, BASE, 8'd3, 3'd3, BURST_INCR, d, rr, lst, rid);
    chk("mid_word0", d[0], 64'hA0);
    chk("mid_word1", d[1], 64'hA1);
    chk("mid_word2", d[2], 64'd3);
    chk("mid_word3", d[3], 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
